// File: rtl/serial_buf_pkg.sv
// Shared definitions for the serial buffer blocks: default frame width,
// receive FSM state encoding and the bit-counter width helper.
package serial_buf_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must be able to hold DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_in_buffer_hold.sv
// Single-entry output register for assembled words: valid/ready handshake,
// overrun detection and the sticky overrun flag.
module serial_in_buffer_hold
  import serial_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_in,
  input  logic [DATA_W-1:0] word_in,
  input  logic              ready_in,
  input  logic              clear_in,
  output logic [DATA_W-1:0] vect_out,
  output logic              valid_out,
  output logic              overrun_out
);

  // Handshake: a word moves to the consumer on any edge where valid_out and
  // ready_in are both high; vect_out is held stable while valid_out is high.
  logic [DATA_W-1:0] r_vect;
  logic              r_valid;
  logic              r_overrun;
  logic              w_xfer;
  logic              w_accept;
  logic              w_overrun_ev;

  assign w_xfer       = r_valid & ready_in;
  assign w_accept     = load_in & (~r_valid | ready_in);
  assign w_overrun_ev = load_in & r_valid & ~ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vect    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vect  <= word_in;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      // A new event outranks a simultaneous clear.
      if (w_overrun_ev)  r_overrun <= 1'b1;
      else if (clear_in) r_overrun <= 1'b0;
    end
  end

  assign vect_out    = r_vect;
  assign valid_out   = r_valid;
  assign overrun_out = r_overrun;

endmodule

// File: rtl/serial_in_buffer.sv
// Serial-to-parallel receiver: start-strobe framed bit stream in, DATA_W-bit
// words out through a single-entry valid/ready holding register.
module serial_in_buffer
  import serial_buf_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              serial_in,
  input  logic              start_in,
  input  logic              ready_in,
  input  logic              clear_in,
  output logic [DATA_W-1:0] vect_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic              overrun_out,
  output logic              frame_err_out,
  output state_t            state_out
);

  localparam int             CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_shift_in;
  logic              w_frame_done;
  logic              w_frame_err;
  logic              r_frame_err;

  // A restarted frame shifts over stale bits; they are all gone by its last bit.
  assign w_shift_in = MSB_FIRST ? {r_shift[DATA_W-2:0], serial_in}
                                : {serial_in, r_shift[DATA_W-1:1]};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      if (w_frame_err)   r_frame_err <= 1'b1;
      else if (clear_in) r_frame_err <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_frame_done = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift_nxt = w_shift_in;
        if (start_in) begin
          w_frame_err = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == CNT_LAST) begin
          w_frame_done = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  serial_in_buffer_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (w_frame_done),
    .word_in     (w_shift_in),
    .ready_in    (ready_in),
    .clear_in    (clear_in),
    .vect_out    (vect_out),
    .valid_out   (valid_out),
    .overrun_out (overrun_out)
  );

  assign busy_out      = (r_state == SHIFT);
  assign frame_err_out = r_frame_err;
  assign state_out     = r_state;

endmodule
